// File: rtl/seq_detect_param_if.sv
// Serial-stream bundle for seq_detect_param: bit/valid/overlap/pattern-load in,
// Mealy match flag and match count out.
interface seq_detect_param_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    logic             in_i;
    logic             in_valid_i;
    logic             overlap_i;
    logic             pat_load_i;
    logic [PAT_W-1:0] pat_in_i;
    logic             out_o;
    logic [CNT_W-1:0] match_cnt_o;

    modport master (
        output in_i, in_valid_i, overlap_i, pat_load_i, pat_in_i,
        input  out_o, match_cnt_o
    );

    modport slave (
        input  in_i, in_valid_i, overlap_i, pat_load_i, pat_in_i,
        output out_o, match_cnt_o
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial-pattern detector with runtime-loadable pattern.
// Optional saturating match counter enabled by defining SEQ_DET_CNT_EN.
module seq_detect_param #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(3'b101),
    parameter int               CNT_W   = 8
) (
    input logic               clk,
    input logic               rst,
    seq_detect_param_if.slave bus
);
    localparam int            FW       = $clog2(PAT_W);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-2:0] hist_q, hist_d, hist_shift;
    logic [FW-1:0]    fill_q, fill_d;
    logic             consume, full, match;

    generate
        if (PAT_W == 2) begin : g_hist_w2
            assign hist_shift = bus.in_i;
        end else begin : g_hist_wn
            assign hist_shift = {hist_q[PAT_W-3:0], bus.in_i};
        end
    endgenerate

    // fill gates the compare so a cleared history can never alias an all-zero pattern
    always_comb begin
        consume = bus.in_valid_i & ~bus.pat_load_i;
        full    = (fill_q == FILL_MAX);
        match   = consume & full & ({hist_q, bus.in_i} == pat_q);
    end

    assign bus.out_o = match & rst;

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (bus.pat_load_i) begin
            pat_d  = bus.pat_in_i;
            hist_d = '0;
            fill_d = '0;
        end else if (consume) begin
            hist_d = hist_shift;
            if (match && !bus.overlap_i)
                fill_d = '0;
            else if (!full)
                fill_d = fill_q + FW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q  <= RST_PAT;
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // a load clears the count even if it coincides with a would-be match
    always_comb begin
        cnt_d = cnt_q;
        if (bus.pat_load_i)
            cnt_d = '0;
        else if (match && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign bus.match_cnt_o = cnt_q;
`else
    assign bus.match_cnt_o = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus randomized stream against a
// queue-based reference model of the last consumed bits.
module tb_seq_detect_param;
    localparam int               PAT_W   = 3;
    localparam int               CNT_W   = 2;
    localparam int               CMAX    = (1 << CNT_W) - 1;
    localparam logic [PAT_W-1:0] RST_PAT = 3'b101;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_detect_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_detect_param #(.PAT_W(PAT_W), .RST_PAT(RST_PAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // reference model: pattern, bits consumed since last clear, saturating count
    logic [PAT_W-1:0] m_pat;
    bit               m_hist[$];
    int               m_cnt;
    logic             exp_out;
    logic [CNT_W-1:0] exp_cnt;

    task automatic model_reset();
        m_pat = RST_PAT;
        m_hist.delete();
        m_cnt = 0;
    endtask

    task automatic drive(input logic b, input logic v, input logic ld, input logic ov,
                         input logic [PAT_W-1:0] p);
        @(negedge clk);
        bus.in_i       = b;
        bus.in_valid_i = v;
        bus.pat_load_i = ld;
        bus.overlap_i  = ov;
        bus.pat_in_i   = p;
        #1;
        exp_out = 1'b0;
        if (rst && v && !ld && (m_hist.size() >= PAT_W - 1)) begin
            exp_out = (b == m_pat[0]);
            for (int i = 0; i < PAT_W - 1; i++)
                if (m_hist[m_hist.size() - 1 - i] != m_pat[i + 1]) exp_out = 1'b0;
        end
`ifdef SEQ_DET_CNT_EN
        exp_cnt = CNT_W'(m_cnt);
`else
        exp_cnt = '0;
`endif
    endtask

    task automatic commit();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (bus.pat_load_i) begin
            m_pat = bus.pat_in_i;
            m_hist.delete();
            m_cnt = 0;
        end else if (bus.in_valid_i) begin
            if (exp_out) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            if (exp_out && !bus.overlap_i) m_hist.delete();
            else begin
                m_hist.push_back(bus.in_i);
                if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.pat_load_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, '0);
        vectors++;
        if (bus.out_o !== 1'b0) begin
            errors++; $display("FAIL reset_out: got %b want 0", bus.out_o);
        end
        vectors++;
        if (bus.match_cnt_o !== '0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", bus.match_cnt_o);
        end
        commit();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_overlap(input logic ov);
        logic [7:0] stim;
        logic [7:0] want;
        stim = 8'b10101101;
        want = ov ? 8'b00101001 : 8'b00100001;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(stim[7-i], 1'b1, 1'b0, ov, '0);
            vectors++;
            if (bus.out_o !== want[7-i]) begin
                errors++; $display("FAIL stream_ov%0d bit%0d: got %b want %b", ov, i + 1, bus.out_o, want[7-i]);
            end
            vectors++;
            if (bus.match_cnt_o !== exp_cnt) begin
                errors++; $display("FAIL stream_cnt_ov%0d bit%0d: got %0d want %0d", ov, i + 1, bus.match_cnt_o, exp_cnt);
            end
            commit();
        end
    endtask

    task automatic test_gap();
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1, '0); commit();
        drive(1'b0, 1'b1, 1'b0, 1'b1, '0); commit();
        for (int g = 0; g < 4; g++) begin
            drive(1'($urandom), 1'b0, 1'b0, 1'b1, '0);
            vectors++;
            if (bus.out_o !== 1'b0) begin
                errors++; $display("FAIL gap_cycle%0d: got %b want 0", g, bus.out_o);
            end
            commit();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, '0);
        vectors++;
        if (bus.out_o !== 1'b1) begin
            errors++; $display("FAIL gap_match: got %b want 1", bus.out_o);
        end
        commit();
    endtask

    task automatic test_load();
        logic [5:0] stim;
        logic [5:0] want;
        stim = 6'b110101;
        want = 6'b001000;
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1, '0); commit();
        drive(1'b1, 1'b1, 1'b0, 1'b1, '0); commit();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b110);
        vectors++;
        if (bus.out_o !== 1'b0) begin
            errors++; $display("FAIL load_cycle: got %b want 0", bus.out_o);
        end
        commit();
        for (int i = 0; i < 6; i++) begin
            drive(stim[5-i], 1'b1, 1'b0, 1'b1, '0);
            vectors++;
            if (bus.out_o !== want[5-i]) begin
                errors++; $display("FAIL load_stream bit%0d: got %b want %b", i + 1, bus.out_o, want[5-i]);
            end
            commit();
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] want;
        want = 3'b001;
        apply_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b011); commit();
        drive(1'b1, 1'b1, 1'b0, 1'b1, '0); commit();
        drive(1'b0, 1'b1, 1'b0, 1'b1, '0); commit();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(want[2-i] | (i == 0 ? 1'b1 : 1'b0), 1'b1, 1'b0, 1'b1, '0);
            vectors++;
            if (bus.out_o !== want[2-i]) begin
                errors++; $display("FAIL reset_mid bit%0d: got %b want %b", i + 1, bus.out_o, want[2-i]);
            end
            commit();
        end
    endtask

    task automatic test_counter();
        int k;
        int want;
        k = 0;
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            drive(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b1, '0);
            commit();
            if ((i % 2) == 0 && i >= 2) begin
                k++;
                #1;
`ifdef SEQ_DET_CNT_EN
                want = (k > CMAX) ? CMAX : k;
`else
                want = 0;
`endif
                vectors++;
                if (bus.match_cnt_o !== CNT_W'(want)) begin
                    errors++; $display("FAIL cnt_match%0d: got %0d want %0d", k, bus.match_cnt_o, want);
                end
            end
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, RST_PAT);
        vectors++;
        if (bus.out_o !== 1'b0) begin
            errors++; $display("FAIL cnt_load_out: got %b want 0", bus.out_o);
        end
        commit();
        #1;
        vectors++;
        if (bus.match_cnt_o !== '0) begin
            errors++; $display("FAIL cnt_load_clear: got %0d want 0", bus.match_cnt_o);
        end
    endtask

    task automatic test_all_same();
        logic [5:0] want_ov;
        logic [5:0] want_nov;
        want_ov  = 6'b001111;
        want_nov = 6'b001001;
        apply_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b111); commit();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, '0);
            vectors++;
            if (bus.out_o !== want_ov[5-i]) begin
                errors++; $display("FAIL ones_ov bit%0d: got %b want %b", i + 1, bus.out_o, want_ov[5-i]);
            end
            commit();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b111); commit();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
            vectors++;
            if (bus.out_o !== want_nov[5-i]) begin
                errors++; $display("FAIL ones_nov bit%0d: got %b want %b", i + 1, bus.out_o, want_nov[5-i]);
            end
            commit();
        end
    endtask

    task automatic test_random();
        logic ov;
        ov = 1'b1;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) ov = ~ov;
            drive(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0), ov,
                  PAT_W'($urandom));
            vectors++;
            if (bus.out_o !== exp_out) begin
                errors++; $display("FAIL rand_out cyc%0d: got %b want %b", i, bus.out_o, exp_out);
            end
            vectors++;
            if (bus.match_cnt_o !== exp_cnt) begin
                errors++; $display("FAIL rand_cnt cyc%0d: got %0d want %0d", i, bus.match_cnt_o, exp_cnt);
            end
            commit();
        end
    endtask

    initial begin
        bus.in_i       = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.overlap_i  = 1'b1;
        bus.pat_load_i = 1'b0;
        bus.pat_in_i   = '0;
        model_reset();
        test_reset();
        test_overlap(1'b1);
        test_overlap(1'b0);
        test_gap();
        test_load();
        test_reset_mid();
        test_counter();
        test_all_same();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
